// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the MiniRISC data memory bus.
//
// Serialises CPU and DMA requests onto the single data memory port as one-cycle
// registered accesses (IDLE -> ACCESS -> DONE), returning read data alongside a
// one-cycle ack. All outputs are registered; bus outputs are zero outside ACCESS
// so the block can sit on a wired-OR bus.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   dbg_is_brk                      breakpoint: blocks new grants
//   cpu_req/wr/addr/wdata           CPU request channel
//   cpu_ack, cpu_rdata              CPU completion pulse and read data
//   dma_req/wr/addr/wdata/lock      DMA request channel, lock asks for a burst
//   dma_ack, dma_rdata              DMA completion pulse and read data
//   mem_addr/dout/wr/rd, mem_din    data memory bus
//   owner                           0 = CPU, 1 = DMA (current or last access)
module dmem_arbiter #(
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dbg_is_brk,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_wr,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  input  logic       dma_lock,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_dout,
  output logic       mem_wr,
  output logic       mem_rd,
  input  logic [7:0] mem_din,
  output logic       owner
);

  localparam logic [3:0] MaxBurst    = 4'(MAX_BURST);
  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic       mem_wr_q, mem_wr_d;
  logic       mem_rd_q, mem_rd_d;
  logic       owner_q, owner_d;
  logic [3:0] burst_q, burst_d;
  logic [3:0] starve_q, starve_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dma_ack_q, dma_ack_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] dma_rdata_q, dma_rdata_d;

  logic both_req;
  logic dma_win;

  assign both_req = cpu_req & dma_req;

  // Winner selection; only meaningful in IDLE with at least one request.
  always_comb begin
    dma_win = dma_req;
    if (both_req) begin
      if (owner_q && dma_lock && (burst_q < MaxBurst)) begin
        dma_win = 1'b1;
      end else if (starve_q >= StarveLimit) begin
        dma_win = 1'b1;
      end else begin
        dma_win = 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = '0;
    mem_dout_d  = '0;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    owner_d     = owner_q;
    burst_d     = burst_q;
    starve_d    = starve_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = '0;
    dma_rdata_d = '0;

    unique case (state_q)
      StIdle: begin
        if (!dbg_is_brk && (cpu_req || dma_req)) begin
          state_d = StAccess;
          owner_d = dma_win;
          if (dma_win) begin
            mem_addr_d = dma_addr;
            mem_wr_d   = dma_wr;
            mem_rd_d   = ~dma_wr;
            mem_dout_d = dma_wr ? dma_wdata : 8'h00;
            starve_d   = '0;
            if (dma_lock) begin
              burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
            end else begin
              burst_d = '0;
            end
          end else begin
            mem_addr_d = cpu_addr;
            mem_wr_d   = cpu_wr;
            mem_rd_d   = ~cpu_wr;
            mem_dout_d = cpu_wr ? cpu_wdata : 8'h00;
            burst_d    = '0;
            if (both_req) begin
              starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
            end
          end
        end
      end
      StAccess: begin
        // Bus outputs fall back to zero (defaults); writes return zero data.
        state_d = StDone;
        if (owner_q) begin
          dma_ack_d   = 1'b1;
          dma_rdata_d = mem_rd_q ? mem_din : 8'h00;
        end else begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = mem_rd_q ? mem_din : 8'h00;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      owner_q     <= 1'b0;
      burst_q     <= '0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign owner     = owner_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-scenario tasks with inline checks,
// plus a scoreboard of expected acks (master and read data) popped on each ack.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dbg_is_brk;
  logic       cpu_req, cpu_wr;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       dma_req, dma_wr, dma_lock;
  logic [7:0] dma_addr, dma_wdata;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic [7:0] mem_addr, mem_dout, mem_din;
  logic       mem_wr, mem_rd, owner;

  logic [7:0] mem [256];
  assign mem_din = mem[mem_addr];

  wire [36:0] all_out = {cpu_ack, cpu_rdata, dma_ack, dma_rdata, mem_addr, mem_dout,
                         mem_wr, mem_rd, owner};

  typedef struct packed {
    logic       dma;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  dmem_arbiter #(
    .MAX_BURST   (4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dbg_is_brk(dbg_is_brk),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_wr    (dma_wr),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_lock  (dma_lock),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_din   (mem_din),
    .owner     (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_inputs();
    dbg_is_brk = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0; dma_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard: every ack pops the oldest expectation; rdata must be 0 without ack.
  task automatic sb_monitor();
    exp_t got;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_ack || dma_ack) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_ack: got cpu_ack=%0b dma_ack=%0b, want no ack",
                     cpu_ack, dma_ack);
          end else begin
            got = sb.pop_front();
            if ({dma_ack, cpu_ack} !== {got.dma, ~got.dma} ||
                (got.dma ? dma_rdata : cpu_rdata) !== got.data) begin
              failures++;
              $display("FAIL sb_ack: got dma_ack=%0b cpu_ack=%0b data=%02h, want dma=%0b data=%02h",
                       dma_ack, cpu_ack, got.dma ? dma_rdata : cpu_rdata, got.dma, got.data);
            end
          end
        end
        checks++;
        if ((!cpu_ack && cpu_rdata !== 8'h00) || (!dma_ack && dma_rdata !== 8'h00)) begin
          failures++;
          $display("FAIL rdata_idle_zero: got cpu_rdata=%02h dma_rdata=%02h, want 00 without ack",
                   cpu_rdata, dma_rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (all_out !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== 37'd0) begin
      failures++;
      $display("FAIL reset_release_idle: got %h, want 0", all_out);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h80;
    sb.push_back({1'b0, mem[8'h80]});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (k == 1) begin
        if ({mem_rd, mem_wr, mem_addr, mem_dout, cpu_ack} !== {1'b1, 1'b0, 8'h80, 8'h00, 1'b0}) begin
          failures++;
          $display("FAIL cpu_read_access: got rd=%0b wr=%0b addr=%02h dout=%02h ack=%0b, want 1 0 80 00 0",
                   mem_rd, mem_wr, mem_addr, mem_dout, cpu_ack);
        end
      end else if (k == 2) begin
        if ({cpu_ack, cpu_rdata, mem_rd, mem_wr, mem_addr} !== {1'b1, 8'h5A, 1'b0, 1'b0, 8'h00}) begin
          failures++;
          $display("FAIL cpu_read_ack: got ack=%0b rdata=%02h rd=%0b wr=%0b addr=%02h, want 1 5a 0 0 00",
                   cpu_ack, cpu_rdata, mem_rd, mem_wr, mem_addr);
        end
        cpu_req = 1'b0;
      end else begin
        if (all_out !== 37'd0) begin
          failures++;
          $display("FAIL cpu_read_quiet: got %h, want 0", all_out);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int acks = 0;
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 8'h20; dma_lock = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) sb.push_back({1'b0, mem[8'h10]});
      sb.push_back({1'b1, mem[8'h20]});
    end
    for (int t = 0; t < 60 && acks < 8; t++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        acks++;
        if (acks == 3) begin
          checks++;
          if (dut.starve_q !== 4'd3) begin
            failures++;
            $display("FAIL starve_count_3: got %0d, want 3", dut.starve_q);
          end
        end
        if (acks == 4) begin
          checks++;
          if (dut.starve_q !== 4'd0) begin
            failures++;
            $display("FAIL starve_clear: got %0d, want 0", dut.starve_q);
          end
        end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checks++;
    if (acks != 8) begin
      failures++;
      $display("FAIL starve_timeout: got %0d acks, want 8", acks);
    end
  endtask

  task automatic test_burst();
    int acks = 0;
    bit cpu_raised = 1'b0;
    do_reset();
    dma_req = 1'b1; dma_wr = 1'b1; dma_wdata = 8'h3C; dma_addr = 8'h40; dma_lock = 1'b1;
    cpu_wr = 1'b0; cpu_addr = 8'h80;
    for (int i = 0; i < 4; i++) sb.push_back({1'b1, 8'h00});
    sb.push_back({1'b0, mem[8'h80]});
    sb.push_back({1'b1, 8'h00});
    for (int t = 0; t < 60 && acks < 6; t++) begin
      @(negedge clk);
      checks++;
      if (mem_wr) begin
        if ({mem_addr, mem_dout, mem_rd} !== {8'h40, 8'h3C, 1'b0}) begin
          failures++;
          $display("FAIL burst_write_bus: got addr=%02h dout=%02h rd=%0b, want 40 3c 0",
                   mem_addr, mem_dout, mem_rd);
        end
        if (!cpu_raised) begin
          cpu_raised = 1'b1;
          cpu_req = 1'b1;
        end
      end else if (mem_rd) begin
        if ({mem_addr, mem_dout} !== {8'h80, 8'h00}) begin
          failures++;
          $display("FAIL burst_cpu_read_bus: got addr=%02h dout=%02h, want 80 00", mem_addr, mem_dout);
        end
      end else if ({mem_addr, mem_dout} !== 16'h0000) begin
        failures++;
        $display("FAIL burst_bus_idle: got addr=%02h dout=%02h, want 00 00", mem_addr, mem_dout);
      end
      if (cpu_ack) cpu_req = 1'b0;
      if (cpu_ack || dma_ack) acks++;
    end
    dma_req = 1'b0; dma_lock = 1'b0; dma_wr = 1'b0;
    checks++;
    if (acks != 6) begin
      failures++;
      $display("FAIL burst_timeout: got %0d acks, want 6", acks);
    end
  endtask

  task automatic test_dbg_freeze();
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h33; cpu_wdata = 8'h77;
    sb.push_back({1'b0, 8'h00});
    @(negedge clk);
    checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_dout} !== {1'b1, 1'b0, 8'h33, 8'h77}) begin
      failures++;
      $display("FAIL dbg_write_access: got wr=%0b rd=%0b addr=%02h dout=%02h, want 1 0 33 77",
               mem_wr, mem_rd, mem_addr, mem_dout);
    end
    dbg_is_brk = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1) begin
      failures++;
      $display("FAIL dbg_write_ack: got %0b, want 1", cpu_ack);
    end
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 8'h20;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if ({mem_wr, mem_rd} !== 2'b00) begin
        failures++;
        $display("FAIL dbg_no_grant: got wr=%0b rd=%0b, want 0 0", mem_wr, mem_rd);
      end
    end
    dbg_is_brk = 1'b0;
    dma_req = 1'b0;
    sb.push_back({1'b0, 8'h00});
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1) begin
      failures++;
      $display("FAIL dbg_resume: got mem_wr=%0b, want 1", mem_wr);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 8'h20;
    @(negedge clk);
    checks++;
    if ({mem_rd, owner} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pre: got rd=%0b owner=%0b, want 1 1", mem_rd, owner);
    end
    dma_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, mem_wr, mem_addr, owner} !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_async: got rd=%0b wr=%0b addr=%02h owner=%0b, want all 0",
               mem_rd, mem_wr, mem_addr, owner);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== 37'd0) begin
      failures++;
      $display("FAIL rst_mid_no_ack: got %h, want 0", all_out);
    end
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h80;
    sb.push_back({1'b0, mem[8'h80]});
    @(negedge clk);
    checks++;
    if ({mem_rd, owner, mem_addr} !== {1'b1, 1'b0, 8'h80}) begin
      failures++;
      $display("FAIL rst_mid_regrant: got rd=%0b owner=%0b addr=%02h, want 1 0 80",
               mem_rd, owner, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_ack_latency: got %0b, want 1", cpu_ack);
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int last = -1;
    do_reset();
    dma_req = 1'b1; dma_wr = 1'b0; dma_lock = 1'b0; dma_addr = 8'h00;
    sb.push_back({1'b1, mem[8'h00]});
    for (int t = 0; t < 100 && acks < 20; t++) begin
      @(negedge clk);
      if (dma_ack) begin
        acks++;
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles, want 3", cyc - last);
          end
        end
        last = cyc;
        checks++;
        if (dut.burst_q !== 4'd0) begin
          failures++;
          $display("FAIL b2b_burst_cnt: got %0d, want 0", dut.burst_q);
        end
        if (acks < 20) begin
          dma_addr = 8'(acks);
          sb.push_back({1'b1, mem[8'(acks)]});
        end
      end
    end
    dma_req = 1'b0;
    checks++;
    if (acks != 20) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d acks, want 20", acks);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 13 + 7);
    mem[8'h80] = 8'h5A;
    idle_inputs();
    fork
      sb_monitor();
    join_none
    test_reset();
    test_cpu_read();
    test_starvation();
    test_burst();
    test_dbg_freeze();
    test_reset_mid_access();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
